pmod_adc_rx: RTL and testbench

- Capture-side counterpart to the synthesizer's 8-bit PMOD DAC output. It reads audio samples from a serial 12-bit ADC (AD7476-style, PMOD AD1) on a Blackboard PMOD port.
- Generates chip-select and serial clock, deserializes each 16-bit frame, and presents a 12-bit sample plus an 8-bit wav-compatible sample with a one-cycle valid strobe.
- Conversions are paced by an internal sample-rate counter, so downstream wav_sel/LUT logic can consume input audio.

---
 rtl/pmod_adc_rx.sv | 182 ++++++++++++++++++
 tb/tb_pmod_adc_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_adc_rx.sv
// pmod_adc_rx: receiver for an AD7476-style 12-bit serial ADC (PMOD AD1).
// Paces conversions from an internal sample-rate counter, drives adc_cs_n and
// adc_sclk, shifts in one 16-bit frame MSB first on adc_sclk rising edges, and
// presents the 12-bit result plus an 8-bit wav sample with a one-cycle strobe.
`timescale 1ns/1ps
module pmod_adc_rx #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2500,
  parameter int QUIET_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic [7:0]  wav,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int PACE_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMR_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [PACE_W-1:0] PACE_LAST  = PACE_W'(SAMPLE_DIV - 1);
  localparam logic [TMR_W-1:0]  DIV_LAST   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  QUIET_LAST = TMR_W'(QUIET_CYC - 1);
  localparam logic [4:0]        BITS_ALL   = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t              state_q, state_d;
  logic [PACE_W-1:0]   pace_q;
  logic                start_tick;
  logic                sdata_q;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                sclk_q, sclk_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]         shift_q, shift_d;
  logic [11:0]         sample_q;
  logic [7:0]          wav_q;
  logic                frame_err_q;
  logic                div_end;
  logic                quiet_end;
  logic                sclk_rise;
  logic                frame_end;

  // Shared phase timer decodes: half-period of sclk and length of QUIET.
  assign div_end   = (tmr_q == DIV_LAST);
  assign quiet_end = (tmr_q == QUIET_LAST);

  // sclk is about to go 0->1: this is the cycle that shifts in a bit.
  assign sclk_rise = (state_q == S_SHIFT) && div_end && !sclk_q;

  // End of the 32nd half period (high phase) after all 16 bits are in.
  assign frame_end = (state_q == S_SHIFT) && div_end && sclk_q && (bit_cnt_q == BITS_ALL);

  // A tick is raised on the wrap of the pacing counter; ticks seen while busy are simply lost.
  assign start_tick = en && (pace_q == PACE_LAST);

  // Pacing counter: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_q <= '0;
    end else if (!en || (pace_q == PACE_LAST)) begin
      pace_q <= '0;
    end else begin
      pace_q <= pace_q + PACE_W'(1);
    end
  end

  // Input register for the serial data line before it reaches the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_q <= 1'b0;
    end else begin
      sdata_q <= adc_sdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_tick) state_d = S_SETUP;
      S_SETUP: if (div_end)    state_d = S_SHIFT;
      S_SHIFT: if (frame_end)  state_d = S_DONE;
      S_DONE:                  state_d = S_QUIET;
      S_QUIET: if (quiet_end)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // FSM outputs: chip select spans SETUP+SHIFT, valid is the single DONE cycle.
  always_comb begin
    adc_cs_n     = !((state_q == S_SETUP) || (state_q == S_SHIFT));
    busy         = (state_q != S_IDLE);
    sample_valid = (state_q == S_DONE);
    adc_sclk     = sclk_q;
    sample       = sample_q;
    wav          = wav_q;
    frame_err    = frame_err_q;
  end

  // Datapath next values: phase timer, serial clock, bit counter and shifter.
  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if ((state_q == S_IDLE) || (state_d != state_q) || ((state_q == S_SHIFT) && div_end)) begin
      tmr_d = '0;
    end

    // sclk idles high; the first toggle in SHIFT is the fall at the SETUP->SHIFT boundary,
    // and the final high phase is left high into DONE.
    sclk_d = sclk_q;
    if (state_q != S_SHIFT) begin
      sclk_d = 1'b1;
    end
    if ((state_q == S_SETUP) && div_end) begin
      sclk_d = 1'b0;
    end
    if ((state_q == S_SHIFT) && div_end && !frame_end) begin
      sclk_d = ~sclk_q;
    end

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (state_q == S_IDLE) begin
      bit_cnt_d = '0;
    end
    if (sclk_rise) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      shift_d   = {shift_q[14:0], sdata_q};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q     <= '0;
      sclk_q    <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      tmr_q     <= tmr_d;
      sclk_q    <= sclk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Result registers: loaded on the way into DONE so they are valid alongside the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q    <= '0;
      wav_q       <= '0;
      frame_err_q <= 1'b0;
    end else if (frame_end) begin
      sample_q    <= shift_q[11:0];
      wav_q       <= shift_q[11:4];
      frame_err_q <= |shift_q[15:12];
    end
  end

endmodule

// File: tb/tb_pmod_adc_rx.sv
// Bench for pmod_adc_rx: ADC serial model, scoreboard of expected captures,
// frame-shape monitor, and corner sequences (reset abort, en drop, dropped ticks).
`timescale 1ns/1ps
module tb_pmod_adc_rx;

  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_DIV = 200;
  localparam int QUIET_CYC  = 8;
  localparam int FRAME_LOW  = CLK_DIV + 32 * CLK_DIV;   // 132 cycles of cs_n low
  localparam int NV         = 6;

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_sample;
    logic [7:0]  exp_wav;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [11:0] s;
    logic [7:0]  w;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n, adc_sclk, sample_valid, frame_err, busy;
  logic [11:0] sample;
  logic [7:0]  wav;

  logic        en_b = 1'b0;
  logic        adc_sdata_b = 1'b0;
  logic        cs_n_b, sclk_b, valid_b, err_b, busy_b;
  logic [11:0] sample_b;
  logic [7:0]  wav_b;

  pmod_adc_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV), .QUIET_CYC(QUIET_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample), .wav(wav),
    .sample_valid(sample_valid), .frame_err(frame_err), .busy(busy)
  );

  // Second instance with a pacing period shorter than a frame plus quiet time.
  pmod_adc_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(100), .QUIET_CYC(QUIET_CYC)) dut_fast (
    .clk(clk), .rst(rst), .en(en_b), .adc_sdata(adc_sdata_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .sample(sample_b), .wav(wav_b),
    .sample_valid(valid_b), .frame_err(err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t exp_pop;
  exp_t model_exp;
  logic [15:0] model_word = 16'h0000;
  logic [15:0] cur_word = 16'h0000;
  int   bit_idx = 15;

  int   valid_cnt = 0;
  int   fall_cnt = 0;
  int   last_valid_cyc = 0;
  int   fall_cyc = 0;
  int   low_cnt = 0;
  int   rise_cnt = 0;
  bit   in_frame = 1'b0;
  logic prev_cs_n = 1'b1;
  logic prev_sclk = 1'b1;
  logic prev_valid = 1'b0;
  logic [20:0] held = '0;
  int   rst_sclk_edges = 0;
  int   rst_cs_low = 0;
  int   vb_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int start;
    start = valid_cnt;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (valid_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int limit, output bit ok);
    int start;
    start = fall_cnt;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (fall_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: a frame word is latched on cs_n fall and its expected result is
  // pushed to the scoreboard; bits then appear MSB first after each sclk fall.
  always @(negedge adc_cs_n) begin
    bit_idx  = 15;
    cur_word = model_word;
    exp_q.push_back(model_exp);
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      #1;
      if (bit_idx >= 0) adc_sdata = cur_word[bit_idx];
      else adc_sdata = 1'b0;
      bit_idx--;
    end
  end

  // Monitor: frame shape, capture results against the scoreboard, strobe width, hold.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      held     = '0;
      if (adc_sclk !== prev_sclk) rst_sclk_edges++;
      if (adc_cs_n !== 1'b1) rst_cs_low++;
    end else begin
      if (!adc_cs_n && prev_cs_n) begin
        in_frame = 1'b1;
        fall_cyc = cyc;
        fall_cnt++;
        low_cnt  = 0;
        rise_cnt = 0;
      end
      if (!adc_cs_n) low_cnt++;
      if (!adc_cs_n && adc_sclk && !prev_sclk) rise_cnt++;
      if (adc_cs_n && !prev_cs_n && in_frame) begin
        chk("cs_low_cycles", low_cnt, FRAME_LOW);
        chk("sclk_rises", rise_cnt, 16);
        in_frame = 1'b0;
      end
    end
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_pop = exp_q.pop_front();
        chk("sample", sample, exp_pop.s);
        chk("wav", wav, exp_pop.w);
        chk("frame_err", frame_err, exp_pop.e);
        chk("valid_latency", cyc - fall_cyc, FRAME_LOW);
      end
      held = {sample, wav, frame_err};
    end else if (!rst) begin
      chk("hold", {sample, wav, frame_err}, held);
    end
    if (prev_valid === 1'b1) chk("valid_width", sample_valid, 0);
    prev_cs_n  = adc_cs_n;
    prev_sclk  = adc_sclk;
    prev_valid = sample_valid;
  end

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      vb_times.push_back(cyc);
      chk("fast_sample", {sample_b, err_b}, 13'h0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[NV];
    bit   ok;
    int   prev_cyc;
    int   vc;
    int   fc;

    vecs[0] = '{16'h0A5C, 12'hA5C, 8'hA5, 1'b0};
    vecs[1] = '{16'h0FFF, 12'hFFF, 8'hFF, 1'b0};
    vecs[2] = '{16'h0000, 12'h000, 8'h00, 1'b0};
    vecs[3] = '{16'h8123, 12'h123, 8'h12, 1'b1};
    vecs[4] = '{16'h0123, 12'h123, 8'h12, 1'b0};
    vecs[5] = '{16'hF001, 12'h001, 8'h00, 1'b1};
    prev_cyc = 0;

    // Reset held: outputs at rest, no serial clock activity.
    repeat (500) @(negedge clk);
    #1;
    chk("rst_sclk_edges", rst_sclk_edges, 0);
    chk("rst_cs_low", rst_cs_low, 0);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_sample", sample, 12'h000);
    chk("rst_wav", wav, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;

    // Table-driven captures with continuous pacing.
    for (int i = 0; i < NV; i++) begin
      model_word = vecs[i].word;
      model_exp  = '{vecs[i].exp_sample, vecs[i].exp_wav, vecs[i].exp_err};
      en = 1'b1;
      wait_valid(500, ok);
      chk("vec_valid_seen", ok, 1);
      if (i > 0) chk("valid_spacing", last_valid_cyc - prev_cyc, SAMPLE_DIV);
      prev_cyc = last_valid_cyc;
    end

    // Reset 60 cycles into a frame: immediate abort, no strobe, clean recovery.
    model_word = 16'h0555;
    model_exp  = '{12'h555, 8'h55, 1'b0};
    wait_fall(300, ok);
    chk("abort_frame_start", ok, 1);
    repeat (60) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_cs_n", adc_cs_n, 1);
    chk("abort_sclk", adc_sclk, 1);
    chk("abort_busy", busy, 0);
    vc = valid_cnt;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_no_valid", valid_cnt, vc);
    chk("abort_sample", sample, 12'h000);
    model_word = 16'h7ABC;
    model_exp  = '{12'hABC, 8'hAB, 1'b1};
    rst = 1'b0;
    wait_valid(400, ok);
    chk("recover_valid_seen", ok, 1);

    // en dropped mid-frame: that frame completes, then nothing more.
    model_word = 16'h0321;
    model_exp  = '{12'h321, 8'h32, 1'b0};
    wait_fall(300, ok);
    chk("endrop_frame_start", ok, 1);
    repeat (40) @(negedge clk);
    #1;
    en = 1'b0;
    wait_valid(200, ok);
    chk("endrop_valid_seen", ok, 1);
    vc = valid_cnt;
    fc = fall_cnt;
    repeat (1000) @(negedge clk);
    #1;
    chk("endrop_no_valid", valid_cnt, vc);
    chk("endrop_no_frame", fall_cnt, fc);

    // Pacing faster than a frame: ticks during busy are dropped, pulses 200 apart.
    en_b = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      #1;
      if (vb_times.size() >= 4) break;
    end
    chk("fast_pulse_count", (vb_times.size() >= 4), 1);
    for (int k = 1; k < 4; k++) begin
      if (k < vb_times.size()) chk("fast_spacing", vb_times[k] - vb_times[k-1], 200);
    end
    en_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
